// File: rtl/uart_rx_fifo_if.sv
// Consumer-side valid/ready stream of the UART receive FIFO.
// With UART_RX_FIFO_ERR_TAG_EN defined the stream also carries m_err.
interface uart_rx_fifo_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic       m_err;

    modport master (output m_valid, output m_data, output m_err, input m_ready);
    modport slave  (input m_valid, input m_data, input m_err, output m_ready);
`else
    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word fall-through, overflow and error status.
// Optional UART_RX_FIFO_ERR_TAG_EN stores errored frames as {err=1, 8'h00} entries and exposes m_err.
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdata_vld,
    input  logic [7:0]               rdata,
    input  logic                     uart_err,
    input  logic                     flush,
    input  logic                     stat_clr,
    uart_rx_fifo_if.master           m,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rx_afull,
    output logic                     rx_ovf,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int EW = 9;
    logic          push_req;
    logic [EW-1:0] wr_entry;
    assign push_req = rdata_vld | uart_err;
    assign wr_entry = rdata_vld ? {1'b0, rdata} : {1'b1, 8'h00};
`else
    localparam int EW = 8;
    logic          push_req;
    logic [EW-1:0] wr_entry;
    assign push_req = rdata_vld;
    assign wr_entry = rdata;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          m_valid_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_evt;
    logic [EW-1:0] head;

    assign full    = (level == LW'(DEPTH));
    assign pop     = m_valid_q & m.m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push_ok = push_req & (~full | pop);
    assign ovf_evt = push_req & full & ~pop & ~flush;

    assign head      = mem[rd_ptr];
    assign m.m_valid = m_valid_q;
    assign m.m_data  = head[7:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign m.m_err   = head[8];
`endif

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        level_nxt = level;
        if (push_ok && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push_ok)
            level_nxt = level - LW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            m_valid_q <= 1'b0;
            rx_afull  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            m_valid_q <= 1'b0;
            rx_afull  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level     <= level_nxt;
            m_valid_q <= (level_nxt != '0);
            rx_afull  <= (level_nxt >= LW'(AFULL_THRESH));
        end
    end

    // NOTE: storage has no reset; the pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= wr_entry;
    end

    // Set events beat stat_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ovf  <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (ovf_evt)
                rx_ovf <= 1'b1;
            else if (stat_clr)
                rx_ovf <= 1'b0;

            if (uart_err) begin
                if (stat_clr)
                    err_cnt <= ERR_CNT_WIDTH'(1);
                else if (!(&err_cnt))
                    err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end else if (stat_clr) begin
                err_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
// Build with +define+UART_RX_FIFO_ERR_TAG_EN to exercise tagged error entries.
module tb_uart_rx_fifo;
    localparam int DEPTH         = 16;
    localparam int AFULL_THRESH  = 12;
    localparam int ERR_CNT_WIDTH = 8;
    localparam int ERR_MAX       = (1 << ERR_CNT_WIDTH) - 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     rdata_vld;
    logic [7:0]               rdata;
    logic                     uart_err;
    logic                     flush;
    logic                     stat_clr;
    logic [$clog2(DEPTH):0]   level;
    logic                     rx_afull;
    logic                     rx_ovf;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    uart_rx_fifo_if m_if ();

    uart_rx_fifo #(
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdata_vld (rdata_vld),
        .rdata     (rdata),
        .uart_err  (uart_err),
        .flush     (flush),
        .stat_clr  (stat_clr),
        .m         (m_if),
        .level     (level),
        .rx_afull  (rx_afull),
        .rx_ovf    (rx_ovf),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {err, data} entries plus status values.
    logic [8:0] q[$];
    int         m_ovf;
    int         m_errc;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ":level"},    32'(level),    32'(q.size()));
        check({ctx, ":m_valid"},  32'(m_if.m_valid), 32'(q.size() != 0));
        check({ctx, ":rx_afull"}, 32'(rx_afull), 32'(q.size() >= AFULL_THRESH));
        check({ctx, ":rx_ovf"},   32'(rx_ovf),   32'(m_ovf));
        check({ctx, ":err_cnt"},  32'(err_cnt),  32'(m_errc));
        if (q.size() != 0) begin
            check({ctx, ":m_data"}, 32'(m_if.m_data), 32'(q[0][7:0]));
`ifdef UART_RX_FIFO_ERR_TAG_EN
            check({ctx, ":m_err"},  32'(m_if.m_err),  32'(q[0][8]));
`endif
        end
    endtask

    // One clock: drive inputs after the falling edge, advance the model, check #1 after the rising edge.
    task automatic step(input logic vld, input logic [7:0] data, input logic err,
                        input logic flsh, input logic clr, input logic rdy, input string ctx);
        logic       push;
        logic [8:0] entry;
        bit         ovf_event;
        @(negedge clk);
        rdata_vld    = vld;
        rdata        = data;
        uart_err     = err;
        flush        = flsh;
        stat_clr     = clr;
        m_if.m_ready = rdy;
        ovf_event    = 1'b0;
`ifdef UART_RX_FIFO_ERR_TAG_EN
        push  = vld | err;
        entry = vld ? {1'b0, data} : {1'b1, 8'h00};
`else
        push  = vld;
        entry = {1'b0, data};
`endif
        if (flsh) begin
            q.delete();
        end else begin
            if (rdy && q.size() != 0)
                void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH)
                    q.push_back(entry);
                else
                    ovf_event = 1'b1;
            end
        end
        if (clr) m_ovf = 0;
        if (ovf_event) m_ovf = 1;
        if (clr) m_errc = 0;
        if (err) m_errc = (m_errc + 1 > ERR_MAX) ? ERR_MAX : m_errc + 1;
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_ovf  = 0;
        m_errc = 0;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pushed;
        int iter;
        rst_n        = 1'b0;
        rdata_vld    = 1'b0;
        rdata        = 8'h00;
        uart_err     = 1'b0;
        flush        = 1'b0;
        stat_clr     = 1'b0;
        m_if.m_ready = 1'b0;
        m_ovf        = 0;
        m_errc       = 0;

        do_reset();

        // Single byte, then accept it.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "single_push");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "single_hold");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "single_pop");

        // Fill to DEPTH, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "fill");
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "drain");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "stat_clr_ovf");

        // Push and pop together while full: accepted, no overflow.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "refill");
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "full_push_pop");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "drain_55");

        // Flush beats a concurrent push.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, "flush_push");
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, "post_flush_push");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "post_flush_pop");

        // Error counter saturation, then clear racing a new error.
        for (int i = 0; i < 300; i++)
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "err_sat");
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, "clr_with_err");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "err_drain");

        // Reset mid-operation discards stored entries.
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset");
        do_reset();

        // Random traffic with random backpressure across pointer wrap.
        pushed = 0;
        iter   = 0;
        while (pushed < 40 && iter < 1000) begin
            int  r;
            logic vld;
            logic err;
            r   = $urandom_range(0, 9);
            vld = (r < 6);
            err = (r == 6);
            if (vld) pushed++;
            step(vld, 8'($urandom), err, 1'b0, 1'b0, 1'($urandom_range(0, 1)), "random");
            iter++;
        end
        check("random_budget", 32'(pushed), 32'd40);
        for (int i = 0; i < DEPTH + 4; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
